// File: rtl/uart_i2c_receiver_if.sv
// Byte stream in from the UART receiver and decoded I2C command out to the master.
interface uart_i2c_receiver_if;
  logic        rx_done_tick;
  logic [7:0]  rx_byte;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [7:0]  cmd_address;
  logic [7:0]  cmd_mode;
  logic [15:0] cmd_data;

  modport master (
    input  rx_done_tick, rx_byte, cmd_ready,
    output cmd_valid, cmd_address, cmd_mode, cmd_data
  );

  modport slave (
    output rx_done_tick, rx_byte, cmd_ready,
    input  cmd_valid, cmd_address, cmd_mode, cmd_data
  );
endinterface

// File: rtl/uart_i2c_receiver.sv
// Decodes FF/address/mode/data/FF frames from the UART into one held I2C command,
// flagging bad stop bytes, inter-byte stalls and bytes arriving while a command waits.
module uart_i2c_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 250000
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_i2c_receiver_if.master  bus,
  output logic                 frame_error,
  output logic [1:0]           error_code,
  output logic                 busy
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Expiry fires on the edge at which the count would reach TIMEOUT_CYCLES-1.
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    IDLE, ADDRESS, MODE, DATA1, DATA2, STOP, ISSUE
  } state_t;

  state_t        state, state_n;
  logic [7:0]    address, address_n;
  logic [7:0]    mode, mode_n;
  logic [15:0]   data, data_n;
  logic          error, error_n;
  logic [1:0]    code, code_n;
  logic [CW-1:0] count, count_n;

  logic       tick;
  logic [7:0] rx;
  assign tick = bus.rx_done_tick;
  assign rx   = bus.rx_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      address <= '0;
      mode    <= '0;
      data    <= '0;
      error   <= 1'b0;
      code    <= '0;
      count   <= '0;
    end else begin
      state   <= state_n;
      address <= address_n;
      mode    <= mode_n;
      data    <= data_n;
      error   <= error_n;
      code    <= code_n;
      count   <= count_n;
    end
  end

  always_comb begin
    state_n   = state;
    address_n = address;
    mode_n    = mode;
    data_n    = data;
    error_n   = 1'b0;
    code_n    = code;
    count_n   = '0;

    case (state)
      IDLE: if (tick && rx == 8'hFF) state_n = ADDRESS;
      ADDRESS: if (tick) begin
        address_n = rx;
        state_n   = MODE;
      end
      MODE: if (tick) begin
        mode_n = rx;
        if (rx[1]) begin
          state_n = DATA1;
        end else begin
          data_n  = '0;
          state_n = STOP;
        end
      end
      DATA1: if (tick) begin
        data_n[7:0] = rx;
        if (mode[0]) begin
          state_n = DATA2;
        end else begin
          data_n[15:8] = '0;
          state_n      = STOP;
        end
      end
      DATA2: if (tick) begin
        data_n[15:8] = rx;
        state_n      = STOP;
      end
      STOP: if (tick) begin
        if (rx == 8'hFF) begin
          state_n = ISSUE;
        end else begin
          state_n = IDLE;
          error_n = 1'b1;
          code_n  = 2'b01;
        end
      end
      ISSUE: begin
        // A byte coinciding with the handshake is treated as if already in IDLE.
        if (bus.cmd_ready) begin
          state_n = (tick && rx == 8'hFF) ? ADDRESS : IDLE;
        end else if (tick) begin
          error_n = 1'b1;
          code_n  = 2'b11;
        end
      end
      default: state_n = IDLE;
    endcase

    if (state inside {ADDRESS, MODE, DATA1, DATA2, STOP} && !tick) begin
      if (count == LIMIT) begin
        state_n = IDLE;
        error_n = 1'b1;
        code_n  = 2'b10;
      end else begin
        count_n = count + 1'b1;
      end
    end
  end

  assign bus.cmd_valid   = (state == ISSUE);
  assign bus.cmd_address = address;
  assign bus.cmd_mode    = mode;
  assign bus.cmd_data    = data;
  assign frame_error     = error;
  assign error_code      = code;
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_uart_i2c_receiver.sv
// Directed and randomized frame checks for uart_i2c_receiver against a frame-level model.
module tb_uart_i2c_receiver;
  localparam int unsigned T = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_error;
  logic [1:0] error_code;
  logic       busy;

  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;

  uart_i2c_receiver_if bus ();

  uart_i2c_receiver #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .frame_error (frame_error),
    .error_code  (error_code),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_done_tick = 1'b1;
    bus.rx_byte      = b;
    step();
    bus.rx_done_tick = 1'b0;
    bus.rx_byte      = 8'h00;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cmd(input string tag, input logic [7:0] a, input logic [7:0] m,
                           input logic [15:0] d);
    check({tag, " valid"}, 32'(bus.cmd_valid), 32'd1);
    check({tag, " addr"},  32'(bus.cmd_address), 32'(a));
    check({tag, " mode"},  32'(bus.cmd_mode), 32'(m));
    check({tag, " data"},  32'(bus.cmd_data), 32'(d));
  endtask

  // Frame-level model: expected command data from the mode byte and data bytes.
  function automatic logic [15:0] model_data(input logic [7:0] m, input logic [7:0] d0,
                                             input logic [7:0] d1);
    if (!m[1]) return 16'h0000;
    return m[0] ? {d1, d0} : {8'h00, d0};
  endfunction

  initial begin
    logic [7:0]  a, m, d0, d1, stopb;
    logic [7:0]  q[$];
    logic        bad, early;
    int unsigned r;

    reset            = 1'b1;
    bus.rx_done_tick = 1'b0;
    bus.rx_byte      = 8'h00;
    bus.cmd_ready    = 1'b0;
    step();
    step();
    check("reset valid", 32'(bus.cmd_valid), 32'd0);
    check("reset addr",  32'(bus.cmd_address), 32'd0);
    check("reset mode",  32'(bus.cmd_mode), 32'd0);
    check("reset data",  32'(bus.cmd_data), 32'd0);
    check("reset err",   32'(frame_error), 32'd0);
    check("reset code",  32'(error_code), 32'd0);
    check("reset busy",  32'(busy), 32'd0);
    reset = 1'b0;
    step();

    // Read-word, held while not ready
    send(8'hFF); send(8'h48); send(8'h01); send(8'hFF);
    check_cmd("rdword", 8'h48, 8'h01, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      step();
      check("rdword hold", 32'(bus.cmd_valid), 32'd1);
    end
    bus.cmd_ready = 1'b1;
    step();
    check("rdword drop valid", 32'(bus.cmd_valid), 32'd0);
    check("rdword busy", 32'(busy), 32'd0);

    // Write-word and write-byte with ready already high
    send(8'hFF); send(8'h90); send(8'h03); send(8'h34); send(8'h12); send(8'hFF);
    check_cmd("wrword", 8'h90, 8'h03, 16'h1234);
    step();
    check("wrword one cycle", 32'(bus.cmd_valid), 32'd0);
    send(8'hFF); send(8'h90); send(8'h02); send(8'hAB); send(8'hFF);
    check_cmd("wrbyte", 8'h90, 8'h02, 16'h00AB);
    step();
    bus.cmd_ready = 1'b0;

    // Bad stop, then recovery
    send(8'hFF); send(8'h48); send(8'h00); send(8'h7E);
    check("badstop err",   32'(frame_error), 32'd1);
    check("badstop code",  32'(error_code), 32'd1);
    check("badstop valid", 32'(bus.cmd_valid), 32'd0);
    check("badstop busy",  32'(busy), 32'd0);
    step();
    check("badstop pulse width", 32'(frame_error), 32'd0);
    send(8'hFF); send(8'h48); send(8'h00); send(8'hFF);
    check_cmd("after badstop", 8'h48, 8'h00, 16'h0000);
    bus.cmd_ready = 1'b1;
    step();
    bus.cmd_ready = 1'b0;

    // Timeout: error rises on the (T-1)th edge after the last accepted byte
    send(8'hFF); send(8'h48);
    early = 1'b0;
    for (int i = 1; i < T - 1; i++) begin
      step();
      if (frame_error !== 1'b0) early = 1'b1;
    end
    check("timeout early", 32'(early), 32'd0);
    step();
    check("timeout err",  32'(frame_error), 32'd1);
    check("timeout code", 32'(error_code), 32'd2);
    check("timeout busy", 32'(busy), 32'd0);
    step();
    check("timeout pulse width", 32'(frame_error), 32'd0);

    // Byte on the expiry cycle wins
    send(8'hFF); send(8'h48);
    repeat (T - 2) step();
    send(8'h01);
    check("expiry byte err",  32'(frame_error), 32'd0);
    check("expiry byte busy", 32'(busy), 32'd1);
    send(8'hFF);
    check_cmd("expiry byte", 8'h48, 8'h01, 16'h0000);

    // Overrun, then a start byte coinciding with the handshake
    bus.cmd_ready = 1'b1;
    step();
    bus.cmd_ready = 1'b0;
    send(8'hFF); send(8'h48); send(8'h03); send(8'h34); send(8'h12); send(8'hFF);
    send(8'h55);
    check("overrun err",  32'(frame_error), 32'd1);
    check("overrun code", 32'(error_code), 32'd3);
    check_cmd("overrun cmd", 8'h48, 8'h03, 16'h1234);
    bus.cmd_ready = 1'b1;
    send(8'hFF);
    bus.cmd_ready = 1'b0;
    check("simul valid", 32'(bus.cmd_valid), 32'd0);
    check("simul busy",  32'(busy), 32'd1);
    check("simul err",   32'(frame_error), 32'd0);
    send(8'h90); send(8'h02); send(8'hAB); send(8'hFF);
    check_cmd("simul frame", 8'h90, 8'h02, 16'h00AB);
    bus.cmd_ready = 1'b1;
    step();
    bus.cmd_ready = 1'b0;

    // Idle noise
    send(8'h00); send(8'h7F); send(8'hFE);
    check("noise err",  32'(frame_error), 32'd0);
    check("noise busy", 32'(busy), 32'd0);

    // Reset mid-frame
    send(8'hFF); send(8'h48); send(8'h03); send(8'h34);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset valid", 32'(bus.cmd_valid), 32'd0);
    check("midreset addr",  32'(bus.cmd_address), 32'd0);
    check("midreset mode",  32'(bus.cmd_mode), 32'd0);
    check("midreset data",  32'(bus.cmd_data), 32'd0);
    check("midreset err",   32'(frame_error), 32'd0);
    check("midreset code",  32'(error_code), 32'd0);
    check("midreset busy",  32'(busy), 32'd0);
    send(8'hFF); send(8'h22); send(8'h03); send(8'h5A); send(8'hC3); send(8'hFF);
    check_cmd("postreset", 8'h22, 8'h03, 16'hC35A);
    bus.cmd_ready = 1'b1;
    step();
    bus.cmd_ready = 1'b0;

    // Randomized frames with gaps below the timeout
    for (int n = 0; n < 24; n++) begin
      a   = 8'($urandom);
      m   = 8'($urandom);
      d0  = 8'($urandom);
      d1  = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      stopb = bad ? 8'($urandom_range(0, 254)) : 8'hFF;
      q = '{8'hFF, a, m};
      if (m[1]) q.push_back(d0);
      if (m[1] && m[0]) q.push_back(d1);
      q.push_back(stopb);
      foreach (q[i]) begin
        r = $urandom_range(0, T - 2);
        repeat (r) step();
        send(q[i]);
      end
      if (bad) begin
        check("rand badstop err",   32'(frame_error), 32'd1);
        check("rand badstop code",  32'(error_code), 32'd1);
        check("rand badstop valid", 32'(bus.cmd_valid), 32'd0);
      end else begin
        check_cmd("rand", a, m, model_data(m, d0, d1));
        r = $urandom_range(0, 3);
        repeat (r) begin
          step();
          check("rand hold", 32'(bus.cmd_valid), 32'd1);
        end
        bus.cmd_ready = 1'b1;
        step();
        bus.cmd_ready = 1'b0;
        check("rand release", 32'(bus.cmd_valid), 32'd0);
        check("rand idle", 32'(busy), 32'd0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_i2c_receiver.md
Name: uart_i2c_receiver

Overview:
- Receives command frames from the PC over the UART receiver core and decodes them into one I2C transaction request for the I2C master.
- It is the PC→sensor counterpart of the I2C→PC bridge and uses the same frame layout: 0xFF start, address, mode, 0–2 data bytes with the low byte first, then 0xFF stop.
- Each valid frame produces one command, held on a valid/ready handshake.
- Malformed frames, stalled frames and bytes that arrive while a command is pending are reported by error pulses.

Parameters:
- TIMEOUT_CYCLES, 250000, idle clock cycles allowed between bytes inside a frame before the frame is aborted. Must be ≥2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx_done_tick  input  1  one-cycle pulse from the UART receiver; rx_byte is valid in that cycle
- rx_byte  input  8  received byte
- cmd_ready  input  1  I2C master can accept a command
- cmd_valid  output  1  decoded command is available
- cmd_address  output  8  I2C device/register address byte
- cmd_mode  output  8  mode byte; bits [1:0]: 00 read byte, 01 read word, 10 write byte, 11 write word
- cmd_data  output  16  write data; first data byte goes to [7:0], second to [15:8]
- frame_error  output  1  one-cycle error pulse
- error_code  output  2  cause of the last error: 01 bad stop, 10 timeout, 11 overrun; held until the next error
- busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset: state IDLE. All outputs 0. Timeout counter 0.
- States: IDLE, ADDRESS, MODE, DATA1, DATA2, STOP, ISSUE. Every transition happens on the clk edge in which rx_done_tick=1, unless stated otherwise.
- IDLE:
  - rx_byte==0xFF → ADDRESS.
  - Any other byte is ignored silently, with no error.
- ADDRESS: load cmd_address←rx_byte (any value, including 0xFF) → MODE.
- MODE: load cmd_mode←rx_byte.
  - mode[1]=0 (read): cmd_data←0, next state STOP.
  - mode[1]=1 (write): next state DATA1.
- DATA1: cmd_data[7:0]←rx_byte.
  - mode[0]=1 → DATA2.
  - mode[0]=0 → cmd_data[15:8]←0, next state STOP.
- DATA2: cmd_data[15:8]←rx_byte → STOP.
- STOP:
  - rx_byte==0xFF → ISSUE. cmd_valid rises in the cycle after the stop byte is accepted.
  - Any other byte → IDLE with frame_error=1 and error_code=01. No command is issued.
- ISSUE:
  - cmd_valid=1. cmd_address, cmd_mode and cmd_data stay stable until the handshake.
  - Handshake (cmd_valid&&cmd_ready sampled at an edge) → IDLE; cmd_valid=0 in the next cycle.
  - Command outputs keep their values after the handshake until the next frame overwrites them.
- Overrun:
  - rx_done_tick in ISSUE without cmd_ready: the byte is dropped, frame_error pulses with error_code=11, and the state stays ISSUE.
  - rx_done_tick in the same cycle as the handshake: the byte is handled as IDLE would handle it (0xFF → ADDRESS, else ignored). No error.
- Timeout:
  - The counter runs only in ADDRESS, MODE, DATA1, DATA2 and STOP.
  - It clears to 0 on every accepted byte and on every state entry.
  - When it reaches TIMEOUT_CYCLES−1 with no rx_done_tick: state → IDLE, frame_error pulses, error_code=10.
  - rx_done_tick in the same cycle as expiry: the byte wins and there is no timeout.
- frame_error is exactly one cycle wide per event. error_code updates in the same cycle as the pulse.
- Reset asserted mid-frame or in ISSUE: next state is IDLE, all outputs 0, the partial frame is discarded and no error is raised.
- Latency: cmd_valid is high one cycle after the edge that accepts the stop byte.

Test Plan:
- Read-word frame: bytes FF,48,01,FF with cmd_ready=0 → cmd_valid=1 the cycle after the last byte; address=0x48, mode=0x01, data=0x0000. Holds for 5 cycles. Raise cmd_ready → cmd_valid=0 next cycle, busy=0.
- Write-word frame: FF,90,03,34,12,FF, cmd_ready=1 → one-cycle cmd_valid with data=0x1234, mode=0x03. Write-byte FF,90,02,AB,FF → data=0x00AB.
- Bad stop: FF,48,00,7E → frame_error one-cycle pulse, error_code=01, cmd_valid never high, state IDLE. A following FF,48,00,FF decodes normally.
- Timeout with TIMEOUT_CYCLES=16: send FF,48 then stall → frame_error exactly 15 cycles after the 0x48 tick, error_code=10, busy=0. Repeat with a byte arriving on the expiry cycle → no error, MODE accepted.
- Overrun/simultaneity: while cmd_valid=1 and cmd_ready=0, send 0x55 → error_code=11, command unchanged. Then send 0xFF in the same cycle cmd_ready=1 → handshake completes, state ADDRESS, no error.
- Idle noise and reset: bytes 00,7F,FE in IDLE → no error, busy=0. Assert reset after FF,48,03,34 → all outputs 0. A fresh full frame then decodes correctly.
